// File: rtl/phi_n_neural_processor_pkg.sv
// Shared constants for the phi-n processor: fixed-point format, oscillator
// angular steps at the 4 kHz update rate, behavioural states and mu table.
package phi_n_neural_processor_pkg;
  localparam int WIDTH_DEF = 18;
  localparam int FRAC_DEF  = 14;
  localparam int ONE       = 1 << FRAC_DEF;
  localparam int NUM_H     = 5;
  localparam int NUM_L     = 5;
  localparam int MU_SR     = 4;

  // round(2*pi*f/4000 * ONE)
  localparam int W_THETA = 152;
  localparam logic [NUM_H-1:0][15:0] W_SR    = {16'd870, 16'd703, 16'd535, 16'd368, 16'd202};
  // layer order L6, L5a, L5b, L4, L23 from index 0
  localparam logic [NUM_L-1:0][15:0] W_LAYER = {16'd1040, 16'd816, 16'd641, 16'd396, 16'd244};

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_MEDITATION = 3'd1,
    ST_AROUSED    = 3'd2
  } state_e;

  typedef struct packed {
    logic [3:0] theta, l6, l5a, l5b, l4, l23;
  } mu_t;

  function automatic mu_t mu_lookup(input logic [2:0] st);
    mu_t m;
    case (st)
      ST_MEDITATION: m = {4'd4, 4'd4, 4'd2, 4'd2, 4'd2, 4'd2};
      ST_AROUSED:    m = {6{4'd6}};
      default:       m = {6{4'd4}};
    endcase
    return m;
  endfunction
endpackage

// File: rtl/phi_n_neural_processor_column.sv
// Thalamic theta pacemaker and five-layer cortical column.
module phi_n_thalamus import phi_n_neural_processor_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] mu,
  output logic signed [WIDTH-1:0] theta_x_int,
  output logic signed [WIDTH-1:0] theta_y_int
);
  hopf_oscillator #(.WIDTH(WIDTH), .FRAC(FRAC), .OMEGA(W_THETA)) u_osc (
    .clk, .rst_n, .en, .mu, .drive('0), .x(theta_x_int), .y(theta_y_int)
  );
endmodule

module phi_n_cortical_column import phi_n_neural_processor_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] theta_x,
  input  logic signed [WIDTH-1:0] col_in,
  input  logic signed [WIDTH-1:0] mu_l6, mu_l5a, mu_l5b, mu_l4, mu_l23,
  output logic signed [WIDTH-1:0] l6_x, l5a_x, l5b_x, l4_x, l23_x
);
  logic [NUM_L-1:0][WIDTH-1:0] mu_v, in_v, x_v, y_v;
  logic unused_y;

  assign mu_v = {mu_l23, mu_l4, mu_l5b, mu_l5a, mu_l6};
  // L6 follows theta, deep layers chain upward, L2/3 takes the column drive
  assign in_v = {col_in, x_v[2:0], theta_x};

  for (genvar i = 0; i < NUM_L; i++) begin : g_layer
    hopf_oscillator #(.WIDTH(WIDTH), .FRAC(FRAC), .OMEGA(int'(W_LAYER[i]))) u_osc (
      .clk, .rst_n, .en, .mu(mu_v[i]), .drive(in_v[i]), .x(x_v[i]), .y(y_v[i])
    );
  end

  assign {l23_x, l4_x, l5b_x, l5a_x, l6_x} = x_v;
  assign unused_y = ^y_v;
endmodule

// File: rtl/phi_n_neural_processor_config_ctrl.sv
// Behavioural-state to per-oscillator mu mapping (purely combinational).
module phi_n_config_ctrl import phi_n_neural_processor_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
)(
  input  logic [2:0]              state_select,
  output logic signed [WIDTH-1:0] mu_dt_theta,
  output logic signed [WIDTH-1:0] mu_dt_l6,
  output logic signed [WIDTH-1:0] mu_dt_l5a,
  output logic signed [WIDTH-1:0] mu_dt_l5b,
  output logic signed [WIDTH-1:0] mu_dt_l4,
  output logic signed [WIDTH-1:0] mu_dt_l23
);
  mu_t mu;
  always_comb mu = mu_lookup(state_select);

  assign mu_dt_theta = WIDTH'(mu.theta);
  assign mu_dt_l6    = WIDTH'(mu.l6);
  assign mu_dt_l5a   = WIDTH'(mu.l5a);
  assign mu_dt_l5b   = WIDTH'(mu.l5b);
  assign mu_dt_l4    = WIDTH'(mu.l4);
  assign mu_dt_l23   = WIDTH'(mu.l23);
endmodule

// File: rtl/phi_n_neural_processor_hopf_oscillator.sv
// Euler-stepped Hopf oscillator; state advances only on the update enable.
module hopf_oscillator import phi_n_neural_processor_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int OMEGA = 0
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] mu,
  input  logic signed [WIDTH-1:0] drive,
  output logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] SAT_HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] INIT = WIDTH'(1 << (FRAC - 2));

  logic signed [PW-1:0] xe, ye, we, r2, gain, dx, dy, xn, yn;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_HI)  return SAT_HI[WIDTH-1:0];
    if (v < -SAT_HI) return -SAT_HI[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  always_comb begin
    xe   = PW'(x);
    ye   = PW'(y);
    we   = PW'(OMEGA);
    r2   = (xe * xe + ye * ye) >>> FRAC;
    gain = (PW'(mu) <<< (FRAC - 2)) - r2;
    dx   = ((gain * xe) >>> (FRAC + 6)) - ((we * ye) >>> FRAC) + (PW'(drive) >>> 4);
    dy   = ((gain * ye) >>> (FRAC + 6)) + ((we * xe) >>> FRAC);
    xn   = xe + dx;
    yn   = ye + dy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= INIT;
      y <= '0;
    end else if (en) begin
      x <= sat(xn);
      y <= sat(yn);
    end
  end
endmodule

// File: rtl/phi_n_neural_processor.sv
// Top: 4 kHz update divider, theta + SR harmonic bank + three columns,
// coherence/status decoding, theta-phase pattern capture and EEG DAC mix.
module phi_n_neural_processor import phi_n_neural_processor_pkg::*; #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int FAST_SIM = 0
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH-1:0]   sensory_input,
  input  logic [2:0]                state_select,
  input  logic signed [WIDTH-1:0]   sr_field_input,
  input  logic [NUM_H*WIDTH-1:0]    sr_field_packed,
  output logic [11:0]               dac_output,
  output logic signed [WIDTH-1:0]   debug_motor_l23,
  output logic signed [WIDTH-1:0]   debug_theta,
  output logic                      ca3_learning,
  output logic                      ca3_recalling,
  output logic [5:0]                ca3_phase_pattern,
  output logic [5:0]                cortical_pattern_out,
  output logic signed [WIDTH-1:0]   f0_x,
  output logic signed [WIDTH-1:0]   f0_y,
  output logic [WIDTH-1:0]          f0_amplitude,
  output logic [NUM_H*WIDTH-1:0]    sr_f_x_packed,
  output logic [NUM_H*WIDTH-1:0]    sr_coherence_packed,
  output logic [NUM_H-1:0]          sie_per_harmonic,
  output logic [NUM_H-1:0]          coherence_mask,
  output logic [WIDTH-1:0]          sr_coherence,
  output logic                      sr_amplification,
  output logic                      beta_quiet,
  output logic [2:0]                theta_phase
);
  localparam int PW  = 2 * WIDTH;
  localparam int DIV = (FAST_SIM != 0) ? 25 : 31250;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};

  function automatic logic [WIDTH-1:0] absv(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic pos(input logic [WIDTH-1:0] v);
    return !v[WIDTH-1] && (|v);
  endfunction

  // octant of (x,y), counter-clockwise from +x, each octant closed at its start angle
  function automatic logic [2:0] octant(input logic signed [WIDTH-1:0] x, y);
    logic [WIDTH-1:0] ax, ay;
    ax = absv(x);
    ay = absv(y);
    if (x == 0 && y == 0)  return 3'd0;
    if (x > 0 && y >= 0)   return (ay < ax) ? 3'd0 : 3'd1;
    if (x <= 0 && y > 0)   return (ax < ay) ? 3'd2 : 3'd3;
    if (x < 0 && y <= 0)   return (ay < ax) ? 3'd4 : 3'd5;
    return (ax < ay) ? 3'd6 : 3'd7;
  endfunction

  logic [14:0] div_cnt;
  logic        clk_4khz_en;

  assign clk_4khz_en = (div_cnt == 15'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= clk_4khz_en ? '0 : div_cnt + 15'd1;
  end

  logic signed [WIDTH-1:0] mu_theta, mu_l6, mu_l5a, mu_l5b, mu_l4, mu_l23;
  logic signed [WIDTH-1:0] theta_x, theta_y;

  phi_n_config_ctrl #(.WIDTH(WIDTH)) config_ctrl (
    .state_select, .mu_dt_theta(mu_theta), .mu_dt_l6(mu_l6), .mu_dt_l5a(mu_l5a),
    .mu_dt_l5b(mu_l5b), .mu_dt_l4(mu_l4), .mu_dt_l23(mu_l23)
  );

  phi_n_thalamus #(.WIDTH(WIDTH), .FRAC(FRAC)) thal (
    .clk, .rst_n, .en(clk_4khz_en), .mu(mu_theta),
    .theta_x_int(theta_x), .theta_y_int(theta_y)
  );

  // column index 0 sensory, 1 assoc, 2 motor; layer index 0 L6 .. 4 L23
  logic [2:0][NUM_L-1:0][WIDTH-1:0] col_x;
  logic unused_layers;

  phi_n_cortical_column #(.WIDTH(WIDTH), .FRAC(FRAC)) col_sensory (
    .clk, .rst_n, .en(clk_4khz_en), .theta_x, .col_in(sensory_input),
    .mu_l6, .mu_l5a, .mu_l5b, .mu_l4, .mu_l23,
    .l6_x(col_x[0][0]), .l5a_x(col_x[0][1]), .l5b_x(col_x[0][2]), .l4_x(col_x[0][3]), .l23_x(col_x[0][4])
  );
  phi_n_cortical_column #(.WIDTH(WIDTH), .FRAC(FRAC)) col_assoc (
    .clk, .rst_n, .en(clk_4khz_en), .theta_x, .col_in($signed(col_x[0][4]) >>> 2),
    .mu_l6, .mu_l5a, .mu_l5b, .mu_l4, .mu_l23,
    .l6_x(col_x[1][0]), .l5a_x(col_x[1][1]), .l5b_x(col_x[1][2]), .l4_x(col_x[1][3]), .l23_x(col_x[1][4])
  );
  phi_n_cortical_column #(.WIDTH(WIDTH), .FRAC(FRAC)) col_motor (
    .clk, .rst_n, .en(clk_4khz_en), .theta_x, .col_in($signed(col_x[1][4]) >>> 2),
    .mu_l6, .mu_l5a, .mu_l5b, .mu_l4, .mu_l23,
    .l6_x(col_x[2][0]), .l5a_x(col_x[2][1]), .l5b_x(col_x[2][2]), .l4_x(col_x[2][3]), .l23_x(col_x[2][4])
  );
  assign unused_layers = ^{col_x[0][2:0], col_x[1][2:0], col_x[2][1:0]};

  logic [NUM_H-1:0][WIDTH-1:0] h_x, h_y, h_in, h_coh;

  for (genvar k = 0; k < NUM_H; k++) begin : g_h
    logic signed [WIDTH-1:0] extra;
    logic signed [PW-1:0]    dotp, mag, sh;
    assign extra   = (k == 0) ? sr_field_input : '0;
    assign h_in[k] = sr_field_packed[k*WIDTH +: WIDTH] + extra;

    hopf_oscillator #(.WIDTH(WIDTH), .FRAC(FRAC), .OMEGA(int'(W_SR[k]))) u_osc (
      .clk, .rst_n, .en(clk_4khz_en), .mu(WIDTH'(MU_SR)), .drive(h_in[k]), .x(h_x[k]), .y(h_y[k])
    );

    always_comb begin
      dotp = PW'($signed(h_x[k])) * PW'(theta_x) + PW'($signed(h_y[k])) * PW'(theta_y);
      mag  = dotp[PW-1] ? -dotp : dotp;
      sh   = mag >>> FRAC;
      h_coh[k] = (|sh[PW-1:WIDTH-1]) ? MAXV : sh[WIDTH-1:0];
    end
    assign coherence_mask[k] = h_coh[k] > WIDTH'(8192);
  end

  assign sr_f_x_packed       = h_x;
  assign sr_coherence_packed = h_coh;
  assign sr_coherence        = h_coh[0];
  assign f0_x                = h_x[0];
  assign f0_y                = h_y[0];

  assign beta_quiet       = absv(col_x[2][2]) < WIDTH'(2048);
  assign sie_per_harmonic = coherence_mask & {NUM_H{beta_quiet}};
  // clearing the lowest set bit leaves something only when two or more are set
  assign sr_amplification = beta_quiet && (|(coherence_mask & (coherence_mask - 5'd1)));

  logic [WIDTH-1:0] ax0, ay0, amax, amin;
  logic [WIDTH:0]   amp;
  always_comb begin
    ax0  = absv(f0_x);
    ay0  = absv(f0_y);
    amax = (ax0 > ay0) ? ax0 : ay0;
    amin = (ax0 > ay0) ? ay0 : ax0;
    amp  = {1'b0, amax} + {2'b0, amin[WIDTH-1:1]};
    f0_amplitude = (amp[WIDTH] | amp[WIDTH-1]) ? MAXV : amp[WIDTH-1:0];
  end

  assign theta_phase   = octant(theta_x, theta_y);
  assign ca3_learning  = theta_phase < 3'd4;
  assign ca3_recalling = !ca3_learning;
  assign debug_theta     = theta_x;
  assign debug_motor_l23 = col_x[2][4];
  assign cortical_pattern_out = {pos(col_x[2][3]), pos(col_x[1][3]), pos(col_x[0][3]),
                                 pos(col_x[2][4]), pos(col_x[1][4]), pos(col_x[0][4])};

  logic [2:0] prev_phase;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_phase        <= '0;
      ca3_phase_pattern <= '0;
    end else begin
      prev_phase <= theta_phase;
      if (prev_phase == 3'd7 && theta_phase == 3'd0) ca3_phase_pattern <= cortical_pattern_out;
    end
  end

  logic signed [WIDTH+1:0] dsum, dval;
  logic [11:0]             dac_next;
  always_comb begin
    dsum = (WIDTH+2)'($signed(col_x[0][4])) + (WIDTH+2)'($signed(col_x[1][4]))
         + (WIDTH+2)'($signed(col_x[2][4])) + (WIDTH+2)'(theta_x);
    dval = (dsum >>> 6) + (WIDTH+2)'(2048);
    if (dval < 0)                      dac_next = 12'd0;
    else if (dval > (WIDTH+2)'(4095))  dac_next = 12'd4095;
    else                               dac_next = dval[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dac_output <= 12'd2048;
    else if (clk_4khz_en) dac_output <= dac_next;
  end
endmodule

// File: tb/tb_phi_n_neural_processor.sv
// Directed bench: reset state, mu table, divider period, one-step oscillator
// arithmetic per vector, then a long free run checking phase flags and latching.
module tb_phi_n_neural_processor;
  localparam int W = 18;
  localparam int H = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic signed [W-1:0]   sensory_input = '0;
  logic [2:0]            state_select = '0;
  logic signed [W-1:0]   sr_field_input = '0;
  logic [H*W-1:0]        sr_field_packed = '0;
  logic [11:0]           dac_output;
  logic signed [W-1:0]   debug_motor_l23, debug_theta, f0_x, f0_y;
  logic                  ca3_learning, ca3_recalling, sr_amplification, beta_quiet;
  logic [5:0]            ca3_phase_pattern, cortical_pattern_out;
  logic [W-1:0]          f0_amplitude, sr_coherence;
  logic [H*W-1:0]        sr_f_x_packed, sr_coherence_packed;
  logic [H-1:0]          sie_per_harmonic, coherence_mask;
  logic [2:0]            theta_phase;

  phi_n_neural_processor #(.WIDTH(W), .FRAC(14), .FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .sensory_input(sensory_input), .state_select(state_select),
    .sr_field_input(sr_field_input), .sr_field_packed(sr_field_packed),
    .dac_output(dac_output), .debug_motor_l23(debug_motor_l23), .debug_theta(debug_theta),
    .ca3_learning(ca3_learning), .ca3_recalling(ca3_recalling),
    .ca3_phase_pattern(ca3_phase_pattern), .cortical_pattern_out(cortical_pattern_out),
    .f0_x(f0_x), .f0_y(f0_y), .f0_amplitude(f0_amplitude),
    .sr_f_x_packed(sr_f_x_packed), .sr_coherence_packed(sr_coherence_packed),
    .sie_per_harmonic(sie_per_harmonic), .coherence_mask(coherence_mask),
    .sr_coherence(sr_coherence), .sr_amplification(sr_amplification),
    .beta_quiet(beta_quiet), .theta_phase(theta_phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // leaves the bench at the negedge right after the next oscillator update
  task automatic wait_update(input string tag);
    int n = 0;
    while (dut.clk_4khz_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (dut.clk_4khz_en !== 1'b1) begin
      checks++;
      $display("FAIL %s: update enable not seen within 100 cycles", tag);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] st;
    int sr_in, sr0, sr1;
    int e_theta, e_motor, e_f0x, e_f0y, e_h1x;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, sat_hits, flag_bad, latches, pend, n;
    logic [5:0] pat;
    logic [2:0] prev_ph;
    logic prev_sign;
    longint r2;

    // x0=4096: r2=1024; mu=4 -> radial +60, mu=2 -> +28, mu=6 -> +92
    // theta y step = 152*4096>>14 = 38; harmonic-0 y step = 202*4096>>14 = 50
    // motor L2/3 drive = (4096>>>2)>>>4 = 64
    vecs[0] = '{3'd0, 0,    0,    0,   4156, 4220, 4156, 50, 4156};
    vecs[1] = '{3'd1, 1600, 0,    0,   4156, 4188, 4256, 50, 4156};
    vecs[2] = '{3'd2, 0,    -800, 0,   4188, 4252, 4106, 50, 4156};
    vecs[3] = '{3'd5, 1000, 600,  320, 4156, 4220, 4256, 50, 4176};

    // reset state with the clock running
    repeat (4) @(negedge clk);
    chk("rst_dac", dac_output, 2048);
    chk("rst_theta", debug_theta, 4096);
    chk("rst_ca3_pattern", ca3_phase_pattern, 0);
    chk("rst_cortical", cortical_pattern_out, 6'h3f);
    chk("rst_phase", theta_phase, 0);
    chk("rst_learning", ca3_learning, 1);
    chk("rst_recalling", ca3_recalling, 0);
    chk("rst_f0_amp", f0_amplitude, 4096);
    chk("rst_coherence", sr_coherence, 1024);
    chk("rst_coh_h3", sr_coherence_packed[3*W +: W], 1024);
    chk("rst_mask", coherence_mask, 0);
    chk("rst_beta_quiet", beta_quiet, 0);
    chk("rst_sr_amp", sr_amplification, 0);
    chk("rst_div_en", dut.clk_4khz_en, 0);

    // mu table
    state_select = 3'd0; #1;
    chk("mu_l5b_s0", dut.config_ctrl.mu_dt_l5b, 4);
    chk("mu_theta_s0", dut.config_ctrl.mu_dt_theta, 4);
    state_select = 3'd1; #1;
    chk("mu_l5b_s1", dut.config_ctrl.mu_dt_l5b, 2);
    chk("mu_theta_s1", dut.config_ctrl.mu_dt_theta, 4);
    chk("mu_l6_s1", dut.config_ctrl.mu_dt_l6, 4);
    chk("mu_l23_s1", dut.config_ctrl.mu_dt_l23, 2);
    state_select = 3'd2; #1;
    chk("mu_theta_s2", dut.config_ctrl.mu_dt_theta, 6);
    chk("mu_l4_s2", dut.config_ctrl.mu_dt_l4, 6);
    state_select = 3'd7; #1;
    chk("mu_l5a_s7", dut.config_ctrl.mu_dt_l5a, 4);

    // one update from reset per vector
    foreach (vecs[i]) begin
      rst_n = 1'b0;
      state_select = vecs[i].st;
      sr_field_input = W'(vecs[i].sr_in);
      sr_field_packed = '0;
      sr_field_packed[0 +: W] = W'(vecs[i].sr0);
      sr_field_packed[W +: W] = W'(vecs[i].sr1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_update($sformatf("v%0d_update", i));
      chk($sformatf("v%0d_theta", i), debug_theta, vecs[i].e_theta);
      chk($sformatf("v%0d_motor_l23", i), debug_motor_l23, vecs[i].e_motor);
      chk($sformatf("v%0d_f0_x", i), f0_x, vecs[i].e_f0x);
      chk($sformatf("v%0d_f0_y", i), f0_y, vecs[i].e_f0y);
      chk($sformatf("v%0d_h1_x", i), $signed(sr_f_x_packed[W +: W]), vecs[i].e_h1x);
      chk($sformatf("v%0d_dac", i), dac_output, 2304);
    end

    // long run: divider period, then free-running properties
    rst_n = 1'b0;
    state_select = 3'd0;
    sensory_input = W'(4096);
    sr_field_input = W'(2048);
    sr_field_packed = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (dut.clk_4khz_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("div_en_width", dut.clk_4khz_en, 0);
    n = 1;
    while (dut.clk_4khz_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("div_period", n, 25);

    sc = 0; sat_hits = 0; flag_bad = 0; latches = 0; pend = 0; pat = '0;
    prev_ph = theta_phase;
    prev_sign = debug_theta[W-1];
    for (int u = 0; u < 1500; u++) begin
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (ca3_learning !== !ca3_recalling || ca3_learning !== (theta_phase < 3'd4)) flag_bad++;
        if (sie_per_harmonic !== (coherence_mask & {H{beta_quiet}})) flag_bad++;
        if (sr_amplification !== (beta_quiet && $countones(coherence_mask) >= 2)) flag_bad++;
        for (int k = 0; k < H; k++)
          if (coherence_mask[k] !== (sr_coherence_packed[k*W +: W] > 8192)) flag_bad++;
        if (pend != 0) begin
          chk("ca3_latch", ca3_phase_pattern, pat);
          pend = 0;
        end
        if (prev_ph == 3'd7 && theta_phase == 3'd0) begin
          pat = cortical_pattern_out;
          pend = 1;
          latches++;
        end
        prev_ph = theta_phase;
        if (debug_theta >= 131071 || debug_theta <= -131071) sat_hits++;
        if (debug_theta[W-1] != prev_sign) begin
          sc++;
          prev_sign = debug_theta[W-1];
        end
      end
    end
    chk("flag_consistency_errors", flag_bad, 0);
    chk("theta_saturation_hits", sat_hits, 0);
    chk("theta_sign_changes_3_to_5", (sc >= 3 && sc <= 5), 1);
    chk("phase_wraps_seen", (latches >= 1), 1);
    r2 = longint'(debug_theta) * longint'(debug_theta) + longint'(dut.thal.theta_y_int) * longint'(dut.thal.theta_y_int);
    chk("theta_amp_settled", (r2 > 64'd225000000 && r2 < 64'd324000000), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
